// File: rtl/fwd_pkg.sv
// Shared operand-select codes and pipeline tracking records for the forwarding
// unit and the EX-stage operand muxes.
package fwd_pkg;

   localparam int unsigned IDX_W = 5;

   typedef logic [IDX_W-1:0] reg_idx_t;
   typedef logic [1:0]       fwd_sel_t;

   localparam fwd_sel_t FWD_RF    = 2'b00;
   localparam fwd_sel_t FWD_WB    = 2'b01;
   localparam fwd_sel_t FWD_EXMEM = 2'b10;

   typedef struct packed {
      logic     valid;
      reg_idx_t rs1;
      reg_idx_t rs2;
      logic     use_rs1;
      logic     use_rs2;
      reg_idx_t rd;
      logic     reg_write;
      logic     mem_read;
   } idex_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      logic     reg_write;
      logic     mem_read;
   } exmem_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      logic     reg_write;
   } memwb_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand-select for one EX-stage source: the youngest in-flight producer of the
// same non-zero register supplies the operand.
module fwd_sel
   import fwd_pkg::*;
(
   input  logic     i_ex_valid,
   input  logic     i_use,
   input  reg_idx_t i_src,
   input  logic     i_exm_valid,
   input  logic     i_exm_reg_write,
   input  reg_idx_t i_exm_rd,
   input  logic     i_mwb_valid,
   input  logic     i_mwb_reg_write,
   input  reg_idx_t i_mwb_rd,
   output fwd_sel_t o_sel
);

   logic w_hit_exm;
   logic w_hit_mwb;

   assign w_hit_exm = i_ex_valid & i_use & i_exm_valid & i_exm_reg_write &
                      (i_exm_rd != '0) & (i_exm_rd == i_src);
   assign w_hit_mwb = i_ex_valid & i_use & i_mwb_valid & i_mwb_reg_write &
                      (i_mwb_rd != '0) & (i_mwb_rd == i_src);

   always_comb begin
      o_sel = FWD_RF;
      if (w_hit_exm) begin
         o_sel = FWD_EXMEM;
      end else if (w_hit_mwb) begin
         o_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control: tracks the EX, MEM and WB occupants
// and drives operand selects, a one-cycle load-use stall and a stall counter.
module forward_ctrl
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        id_valid,
   input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
   input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
   input  logic                        id_use_rs1,
   input  logic                        id_use_rs2,
   input  logic [$clog2(NUM_REGS)-1:0] id_rd,
   input  logic                        id_reg_write,
   input  logic                        id_mem_read,
   input  logic                        flush,
   output logic [1:0]                  fwd_a,
   output logic [1:0]                  fwd_b,
   output logic                        stall,
   output logic [CNT_W-1:0]            stall_count
);

   // Indices are widened to the package index width; NUM_REGS must not exceed 32.
   reg_idx_t w_rs1;
   reg_idx_t w_rs2;
   reg_idx_t w_rd;

   assign w_rs1 = IDX_W'(id_rs1);
   assign w_rs2 = IDX_W'(id_rs2);
   assign w_rd  = IDX_W'(id_rd);

   idex_t            r_idex;
   exmem_t           r_exmem;
   memwb_t           r_memwb;
   logic [CNT_W-1:0] r_cnt;
   idex_t            w_idex_d;
   logic             w_hazard;
   logic             w_stall;
   logic             w_unused_exm_ld;

   // Load data is only consumed via the WB path, so EX/MEM never needs mem_read.
   assign w_unused_exm_ld = r_exmem.mem_read;

   assign w_hazard = id_valid & r_idex.valid & r_idex.mem_read & (r_idex.rd != '0) &
                     ((id_use_rs1 & (w_rs1 == r_idex.rd)) |
                      (id_use_rs2 & (w_rs2 == r_idex.rd)));
   assign w_stall  = w_hazard & ~flush;

   always_comb begin
      w_idex_d = '0;
      if (id_valid & ~w_stall & ~flush) begin
         w_idex_d.valid     = 1'b1;
         w_idex_d.rs1       = w_rs1;
         w_idex_d.rs2       = w_rs2;
         w_idex_d.use_rs1   = id_use_rs1;
         w_idex_d.use_rs2   = id_use_rs2;
         w_idex_d.rd        = w_rd;
         w_idex_d.reg_write = id_reg_write;
         w_idex_d.mem_read  = id_mem_read;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idex  <= '0;
         r_exmem <= '0;
         r_memwb <= '0;
         r_cnt   <= '0;
      end else begin
         r_idex  <= w_idex_d;
         r_exmem <= '{valid: r_idex.valid, rd: r_idex.rd, reg_write: r_idex.reg_write,
                      mem_read: r_idex.mem_read};
         r_memwb <= '{valid: r_exmem.valid, rd: r_exmem.rd, reg_write: r_exmem.reg_write};
         if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   fwd_sel u_sel_a (
      .i_ex_valid      (r_idex.valid),
      .i_use           (r_idex.use_rs1),
      .i_src           (r_idex.rs1),
      .i_exm_valid     (r_exmem.valid),
      .i_exm_reg_write (r_exmem.reg_write),
      .i_exm_rd        (r_exmem.rd),
      .i_mwb_valid     (r_memwb.valid),
      .i_mwb_reg_write (r_memwb.reg_write),
      .i_mwb_rd        (r_memwb.rd),
      .o_sel           (fwd_a)
   );

   fwd_sel u_sel_b (
      .i_ex_valid      (r_idex.valid),
      .i_use           (r_idex.use_rs2),
      .i_src           (r_idex.rs2),
      .i_exm_valid     (r_exmem.valid),
      .i_exm_reg_write (r_exmem.reg_write),
      .i_exm_rd        (r_exmem.rd),
      .i_mwb_valid     (r_memwb.valid),
      .i_mwb_reg_write (r_memwb.reg_write),
      .i_mwb_rd        (r_memwb.rd),
      .o_sel           (fwd_b)
   );

   assign stall       = w_stall;
   assign stall_count = r_cnt;

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed hazard scenarios plus random
// instruction streams checked against an instruction-level pipeline model.
module tb_forward_ctrl;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   typedef struct packed {
      bit valid;
      int rd;
      int rs1;
      int rs2;
      bit u1;
      bit u2;
      bit wr;
      bit ld;
   } ins_t;

   logic       clk, reset, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, flush;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [1:0] fwd_a, fwd_b;
   logic       stall;
   logic [CNT_W-1:0] stall_count;

   int   n_checks = 0;
   int   n_pass   = 0;
   ins_t st[3];
   int   m_cnt;
   ins_t cur_d;
   bit   cur_fl;
   ins_t NOP;

   forward_ctrl #(.NUM_REGS(32), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: st[0] is the instruction in EX, st[1] in MEM, st[2] in WB.
   function automatic bit m_stall(ins_t d, bit fl);
      if (fl || !d.valid) return 1'b0;
      return st[0].valid && st[0].ld && st[0].rd != 0 &&
             ((d.u1 && d.rs1 == st[0].rd) || (d.u2 && d.rs2 == st[0].rd));
   endfunction

   function automatic logic [1:0] m_fwd(bit u, int src);
      if (!st[0].valid || !u) return 2'b00;
      if (st[1].valid && st[1].wr && st[1].rd != 0 && st[1].rd == src) return 2'b10;
      if (st[2].valid && st[2].wr && st[2].rd != 0 && st[2].rd == src) return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         st[0] <= '0;
         st[1] <= '0;
         st[2] <= '0;
         m_cnt <= 0;
      end else begin
         if (m_stall(cur_d, cur_fl) && m_cnt < CMAX) m_cnt <= m_cnt + 1;
         st[2] <= st[1];
         st[1] <= st[0];
         st[0] <= (cur_d.valid && !cur_fl && !m_stall(cur_d, cur_fl)) ? cur_d : '0;
      end
   end

   function automatic ins_t alu(int rd, int rs1, int rs2);
      ins_t i = '0;
      i.valid = 1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1; i.u2 = 1; i.wr = 1;
      return i;
   endfunction

   function automatic ins_t lw(int rd, int rs1);
      ins_t i = '0;
      i.valid = 1; i.rd = rd; i.rs1 = rs1; i.u1 = 1; i.wr = 1; i.ld = 1;
      return i;
   endfunction

   // Present one decode-slot instruction for a cycle; outputs settle 1 time unit later.
   task automatic drive(input ins_t d, input bit fl);
      @(negedge clk);
      id_valid     = d.valid;
      id_rs1       = d.rs1[4:0];
      id_rs2       = d.rs2[4:0];
      id_rd        = d.rd[4:0];
      id_use_rs1   = d.u1;
      id_use_rs2   = d.u2;
      id_reg_write = d.wr;
      id_mem_read  = d.ld;
      flush        = fl;
      cur_d        = d;
      cur_fl       = fl;
      #1;
   endtask

   task automatic drain();
      repeat (3) drive(NOP, 1'b0);
   endtask

   task automatic test_reset();
      drive(alu(5, 5, 5), 1'b0);
      n_checks++; if (fwd_a !== 2'b00) $display("FAIL reset_fwd_a: got %b expected 00", fwd_a); else n_pass++;
      n_checks++; if (fwd_b !== 2'b00) $display("FAIL reset_fwd_b: got %b expected 00", fwd_b); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
      n_checks++; if (stall_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", stall_count); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      drive(NOP, 1'b0);
      n_checks++; if (fwd_a !== 2'b00 || stall !== 1'b0) $display("FAIL post_reset: got fwd_a=%b stall=%b expected 00/0", fwd_a, stall); else n_pass++;
   endtask

   task automatic test_exmem_fwd();
      drain();
      drive(alu(5, 1, 2), 1'b0);
      drive(alu(6, 5, 7), 1'b0);
      drive(NOP, 1'b0);
      n_checks++; if (fwd_a !== 2'b10) $display("FAIL exmem_fwd_a: got %b expected 10", fwd_a); else n_pass++;
      n_checks++; if (fwd_b !== 2'b00) $display("FAIL exmem_fwd_b: got %b expected 00", fwd_b); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL exmem_stall: got %b expected 0", stall); else n_pass++;
   endtask

   task automatic test_memwb_fwd();
      drain();
      drive(alu(5, 1, 2), 1'b0);
      drive(NOP, 1'b0);
      drive(alu(8, 1, 5), 1'b0);
      drive(NOP, 1'b0);
      n_checks++; if (fwd_b !== 2'b01) $display("FAIL memwb_fwd_b: got %b expected 01", fwd_b); else n_pass++;
      n_checks++; if (fwd_a !== 2'b00) $display("FAIL memwb_fwd_a: got %b expected 00", fwd_a); else n_pass++;
      drain();
      drive(alu(5, 1, 2), 1'b0);
      drive(alu(5, 3, 4), 1'b0);
      drive(alu(8, 1, 5), 1'b0);
      drive(NOP, 1'b0);
      n_checks++; if (fwd_b !== 2'b10) $display("FAIL priority_fwd_b: got %b expected 10", fwd_b); else n_pass++;
   endtask

   task automatic test_load_use();
      int base;
      drain();
      base = m_cnt;
      drive(lw(7, 1), 1'b0);
      drive(alu(9, 7, 2), 1'b0);
      n_checks++; if (stall !== 1'b1) $display("FAIL ldu_stall: got %b expected 1", stall); else n_pass++;
      n_checks++; if (stall_count !== 4'(base)) $display("FAIL ldu_count0: got %0d expected %0d", stall_count, base); else n_pass++;
      drive(alu(9, 7, 2), 1'b0);
      n_checks++; if (stall !== 1'b0) $display("FAIL ldu_one_cycle: got %b expected 0", stall); else n_pass++;
      n_checks++; if (stall_count !== 4'(base + 1)) $display("FAIL ldu_count1: got %0d expected %0d", stall_count, base + 1); else n_pass++;
      drive(NOP, 1'b0);
      n_checks++; if (fwd_a !== 2'b01) $display("FAIL ldu_fwd_a: got %b expected 01", fwd_a); else n_pass++;
      // Back-to-back dependent loads: each produces its own single stall.
      drain();
      drive(lw(7, 1), 1'b0);
      drive(lw(8, 7), 1'b0);
      drive(lw(8, 7), 1'b0);
      n_checks++; if (stall !== 1'b0) $display("FAIL b2b_first_len: got %b expected 0", stall); else n_pass++;
      drive(alu(9, 8, 0), 1'b0);
      n_checks++; if (stall !== 1'b1) $display("FAIL b2b_second: got %b expected 1", stall); else n_pass++;
      drive(alu(9, 8, 0), 1'b0);
      n_checks++; if (stall_count !== 4'(base + 3)) $display("FAIL b2b_count: got %0d expected %0d", stall_count, base + 3); else n_pass++;
   endtask

   task automatic test_x0();
      drain();
      drive(alu(0, 1, 2), 1'b0);
      drive(alu(9, 0, 0), 1'b0);
      drive(NOP, 1'b0);
      n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) $display("FAIL x0_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); else n_pass++;
      drain();
      drive(lw(0, 1), 1'b0);
      drive(alu(9, 0, 0), 1'b0);
      n_checks++; if (stall !== 1'b0) $display("FAIL x0_stall: got %b expected 0", stall); else n_pass++;
      drive(NOP, 1'b0);
      n_checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) $display("FAIL x0_ld_fwd: got %b/%b expected 00/00", fwd_a, fwd_b); else n_pass++;
   endtask

   task automatic test_flush();
      int base;
      drain();
      base = m_cnt;
      drive(lw(7, 1), 1'b0);
      drive(alu(9, 7, 2), 1'b1);
      n_checks++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall); else n_pass++;
      // A dependent decode now sees a bubble in EX, so no stall.
      drive(alu(9, 7, 2), 1'b0);
      n_checks++; if (stall !== 1'b0) $display("FAIL flush_bubble: got %b expected 0", stall); else n_pass++;
      n_checks++; if (stall_count !== 4'(base)) $display("FAIL flush_count: got %0d expected %0d", stall_count, base); else n_pass++;
   endtask

   task automatic test_reset_mid();
      drain();
      drive(lw(7, 1), 1'b0);
      drive(alu(9, 7, 2), 1'b0);
      n_checks++; if (stall !== 1'b1) $display("FAIL rst_pre_stall: got %b expected 1", stall); else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", stall); else n_pass++;
      n_checks++; if (stall_count !== 4'd0) $display("FAIL rst_count: got %0d expected 0", stall_count); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(alu(9, 7, 2), 1'b0);
      n_checks++; if (stall !== 1'b0) $display("FAIL rst_after_stall: got %b expected 0", stall); else n_pass++;
      drive(NOP, 1'b0);
      n_checks++; if (fwd_a !== 2'b00) $display("FAIL rst_after_fwd: got %b expected 00", fwd_a); else n_pass++;
   endtask

   task automatic test_saturate();
      repeat (CMAX + 2) begin
         drive(lw(7, 1), 1'b0);
         drive(alu(9, 7, 2), 1'b0);
         drive(alu(9, 7, 2), 1'b0);
      end
      drive(lw(7, 1), 1'b0);
      drive(alu(9, 7, 2), 1'b0);
      n_checks++; if (stall !== 1'b1 || stall_count !== 4'(CMAX)) $display("FAIL sat_pre: got stall=%b cnt=%0d expected 1/%0d", stall, stall_count, CMAX); else n_pass++;
      drive(alu(9, 7, 2), 1'b0);
      n_checks++; if (stall_count !== 4'(CMAX)) $display("FAIL sat_hold: got %0d expected %0d", stall_count, CMAX); else n_pass++;
   endtask

   task automatic test_random();
      ins_t d;
      bit   fl;
      bit   held = 1'b0;
      reset = 1'b1;
      #1;
      @(negedge clk);
      reset = 1'b0;
      d = NOP;
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            d       = '0;
            d.valid = ($urandom_range(0, 7) != 0);
            d.rd    = $urandom_range(0, 3);
            d.rs1   = $urandom_range(0, 3);
            d.rs2   = $urandom_range(0, 3);
            d.u1    = 1'($urandom_range(0, 1));
            d.u2    = 1'($urandom_range(0, 1));
            d.wr    = ($urandom_range(0, 3) != 0);
            d.ld    = ($urandom_range(0, 2) == 0);
            if (d.ld) d.wr = 1'b1;
         end
         fl = ($urandom_range(0, 7) == 0);
         drive(d, fl);
         n_checks++; if (fwd_a !== m_fwd(st[0].u1, st[0].rs1)) $display("FAIL rnd_fwd_a[%0d]: got %b expected %b", n, fwd_a, m_fwd(st[0].u1, st[0].rs1)); else n_pass++;
         n_checks++; if (fwd_b !== m_fwd(st[0].u2, st[0].rs2)) $display("FAIL rnd_fwd_b[%0d]: got %b expected %b", n, fwd_b, m_fwd(st[0].u2, st[0].rs2)); else n_pass++;
         n_checks++; if (stall !== m_stall(d, fl)) $display("FAIL rnd_stall[%0d]: got %b expected %b", n, stall, m_stall(d, fl)); else n_pass++;
         n_checks++; if (stall_count !== 4'(m_cnt)) $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, stall_count, m_cnt); else n_pass++;
         held = m_stall(d, fl);
      end
   endtask

   initial begin
      NOP = '0;
      cur_d = '0;
      cur_fl = 1'b0;
      reset = 1'b1;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_reg_write = 0; id_mem_read = 0; flush = 0;
      test_reset();
      test_exmem_fwd();
      test_memwb_fwd();
      test_load_use();
      test_x0();
      test_flush();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
